alu_wb_stage: RTL and testbench
===============================

# alu_wb_stage

Writeback/retire stage directly downstream of the 32-bit ALU. It captures each ALU result together with its carry/zero/overflow/sign flags and destination register index into a 2-entry elastic buffer. It then presents results in order to the register-file write port with a valid/ready handshake. When a buffered result retires, its flags are committed into an architectural status register, so the status register always reflects the last retired flag-writing operation.

## Interface
- DWIDTH, 32, data width of result (matches ALU).
- AWIDTH, 4, destination register index width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result/flags/dest valid this cycle.
- in_ready  output  1  stage can accept an entry this cycle.
- in_result  input  DWIDTH  ALU result.
- in_c, in_z, in_o, in_s  input  1 each  ALU carry, zero, overflow, sign flags.
- in_flag_we  input  1  this operation updates status on retire.
- in_dest  input  AWIDTH  destination register index.
- out_valid  output  1  head entry valid for register-file write.
- out_ready  input  1  register file accepts head entry.
- out_result  output  DWIDTH  head entry result.
- out_dest  output  AWIDTH  head entry destination.
- status  output  4  committed flags {s,o,z,c}.
- ovf_cnt  output  8  retired-overflow counter (see Configuration).

## Operation
- Storage: 2 entries {result, c, z, o, s, flag_we, dest}, in-order FIFO with head/tail pointers and 2-bit count (0..2).
- Push: in_valid && in_ready; entry written at tail, tail toggles.
- Pop (retire): out_valid && out_ready; head toggles.
- in_ready = (count != 2), from registered count only; no combinational path from out_ready.
- out_valid = (count != 0); out_result/out_dest driven from head entry, stable while out_valid && !out_ready.
- Simultaneous push and pop: allowed at count 1 (count stays 1), at count 0 (push only; pop impossible), never at count 2 (in_ready low).
- in_valid while in_ready low: ignored, no state change; upstream must hold data.
- Status commit: on pop, if head flag_we = 1, status <= {s,o,z,c} of head; else status unchanged.
- Flags of unretired entries never affect status.
- Data widths pass through unmodified; no arithmetic on result.

## Timing
- Reset (synchronous, rst high at clk edge): count=0, head=tail=0, in_ready=1, out_valid=0, out_result=0, out_dest=0, status=4'b0000, ovf_cnt=0. Buffer contents cleared to 0.
- rst mid-operation: all buffered entries discarded without retiring; status not updated by discarded entries.
- Latency: entry pushed at edge N is visible on out_* after edge N (out_valid high in cycle N+1) when buffer was empty.
- Status updates at the same edge as the pop; visible the following cycle.
- Throughput: 1 entry/cycle sustained when out_ready held high.
- Full: after two pushes with no pop, in_ready low next cycle; it returns high the cycle after the first pop.

## Configuration
- ALU_WB_OVF_CNT_EN defined: ovf_cnt is an 8-bit counter incremented on each pop whose head entry has o=1 and flag_we=1. It saturates at 8'hFF and is reset to 0 by rst.
- Not defined: counter logic absent; ovf_cnt tied to 8'h00.

## Test plan
- Reset then single push result=32'h0000_0005, dest=3, flags c=0 z=0 o=0 s=0, flag_we=1, out_ready=1 -> out_valid high one cycle with 5/dest 3; status=4'b0000 after retire.
- out_ready=0, push 32'hAAAA_AAAA then 32'h5555_5555 -> in_ready low after second push; third in_valid ignored; on out_ready=1, outputs retire in order AAAA_AAAA then 5555_5555.
- Push z=1 flag_we=1 then c=1 flag_we=0; retire both -> status=4'b0010 after first and unchanged after second.
- Push/pop same cycle at count 1 for 10 consecutive cycles -> count stays 1, every result retired exactly once, in order.
- Two entries buffered, including one with s=1 flag_we=1, then rst asserted -> out_valid=0, in_ready=1, status=0 next cycle; the s=1 entry never reaches status.
- With ALU_WB_OVF_CNT_EN: retire 300 entries o=1 flag_we=1 -> ovf_cnt=8'hFF; without macro -> ovf_cnt=0 throughout.

Source files
------------

// File: rtl/alu_wb_stage.sv
// Writeback/retire stage: 2-entry in-order elastic buffer between the ALU and the
// register-file write port, committing flags to a status register on retire.
// Optional: define ALU_WB_OVF_CNT_EN to enable the saturating retired-overflow counter.
module alu_wb_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_result,
  input  logic              in_c,
  input  logic              in_z,
  input  logic              in_o,
  input  logic              in_s,
  input  logic              in_flag_we,
  input  logic [AWIDTH-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_result,
  output logic [AWIDTH-1:0] out_dest,
  output logic [3:0]        status,
  output logic [7:0]        ovf_cnt
);

  logic [DWIDTH-1:0] buf_result [2];
  logic [AWIDTH-1:0] buf_dest   [2];
  logic [3:0]        buf_flags  [2];
  logic              buf_fwe    [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  // Handshake readiness depends only on registered occupancy, never on out_ready.
  assign in_ready   = (count != 2'd2);
  assign out_valid  = (count != 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_result = buf_result[head];
  assign out_dest   = buf_dest[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_result[0] <= '0;
      buf_result[1] <= '0;
      buf_dest[0]   <= '0;
      buf_dest[1]   <= '0;
      buf_flags[0]  <= '0;
      buf_flags[1]  <= '0;
      buf_fwe[0]    <= 1'b0;
      buf_fwe[1]    <= 1'b0;
      head          <= 1'b0;
      tail          <= 1'b0;
      count         <= '0;
      status        <= '0;
    end else begin
      if (push) begin
        buf_result[tail] <= in_result;
        buf_dest[tail]   <= in_dest;
        buf_flags[tail]  <= {in_s, in_o, in_z, in_c};
        buf_fwe[tail]    <= in_flag_we;
        tail             <= ~tail;
      end
      if (pop) begin
        head <= ~head;
        if (buf_fwe[head]) begin
          status <= buf_flags[head];
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_WB_OVF_CNT_EN
  logic [7:0] ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (pop && buf_fwe[head] && buf_flags[head][2] && (ovf_q != '1)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: accepted pushes are queued with their flags,
// retires are checked in order, and status/ovf_cnt are tracked by a reference model.
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_c, in_z, in_o, in_s;
  logic        in_flag_we;
  logic [3:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_dest;
  logic [3:0]  status;
  logic [7:0]  ovf_cnt;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  dest;
    logic [3:0]  flags;
    logic        fwe;
  } entry_t;

  entry_t      sb[$];
  logic [3:0]  m_status;
  logic [7:0]  m_ovf;
  logic        mon_en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;

  alu_wb_stage #(.DWIDTH(32), .AWIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_c(in_c), .in_z(in_z), .in_o(in_o), .in_s(in_s),
    .in_flag_we(in_flag_we), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest),
    .status(status), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are stable at negedge, so this sees exactly what the next edge will act on.
  always @(negedge clk) begin
    if (mon_en) begin
      entry_t e;
      chk("status", {28'd0, status}, {28'd0, m_status});
      chk("ovf_cnt", {24'd0, ovf_cnt}, {24'd0, m_ovf});
      if (rst) begin
        sb.delete();
        m_status = '0;
        m_ovf    = '0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("pop_empty_sb", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            n_pop++;
            chk("out_result", out_result, e.result);
            chk("out_dest", {28'd0, out_dest}, {28'd0, e.dest});
            if (e.fwe) m_status = e.flags;
`ifdef ALU_WB_OVF_CNT_EN
            if (e.fwe && e.flags[2] && m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
`endif
          end
        end
        if (in_valid && in_ready) begin
          e.result = in_result;
          e.dest   = in_dest;
          e.flags  = {in_s, in_o, in_z, in_c};
          e.fwe    = in_flag_we;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] r, input logic [3:0] d, input logic [3:0] f, input logic fwe);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_result = r; in_dest = d;
    {in_s, in_o, in_z, in_c} = f;
    in_flag_we = fwe;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    out_ready = 1'b1;
    for (i = 0; i < 100 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_dest = '0;
    {in_s, in_o, in_z, in_c} = '0; in_flag_we = 1'b0; out_ready = 1'b0;
    m_status = '0; m_ovf = '0;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_dest", {28'd0, out_dest}, 32'd0);
    chk("rst_status", {28'd0, status}, 32'd0);
    chk("rst_ovf", {24'd0, ovf_cnt}, 32'd0);

    // Single push, immediate retire
    out_ready = 1'b1;
    send(32'h0000_0005, 4'd3, 4'b0000, 1'b1);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_result", out_result, 32'h0000_0005);
    chk("single_dest", {28'd0, out_dest}, 32'd3);
    tick();
    chk("single_done", {31'd0, out_valid}, 32'd0);
    chk("single_status", {28'd0, status}, 32'd0);

    // Fill, blocked third push, in-order drain
    out_ready = 1'b0;
    send(32'hAAAA_AAAA, 4'd1, 4'b0000, 1'b0);
    send(32'h5555_5555, 4'd2, 4'b0000, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_result = 32'hDEAD_BEEF; in_dest = 4'd9;
    repeat (3) tick();
    chk("full_hold_ready", {31'd0, in_ready}, 32'd0);
    chk("full_hold_head", out_result, 32'hAAAA_AAAA);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
    drain();
    chk("full_sb_empty", sb.size(), 32'd0);

    // Status commit only for flag-writing ops
    out_ready = 1'b0;
    send(32'h0000_0000, 4'd4, 4'b0010, 1'b1);
    send(32'h0000_0001, 4'd5, 4'b0001, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("status_z", {28'd0, status}, 32'h2);
    tick();
    chk("status_hold", {28'd0, status}, 32'h2);

    // Sustained push+pop at count 1
    n_pop = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_flag_we = 1'b0; {in_s, in_o, in_z, in_c} = '0;
    for (int i = 0; i < 10; i++) begin
      in_result = 32'd100 + i; in_dest = 4'(i);
      tick();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    drain();
    chk("stream_pops", n_pop, 32'd10);

    // Reset discards buffered entries, including an s=1 flag writer
    out_ready = 1'b0;
    send(32'h1234_5678, 4'd6, 4'b1000, 1'b1);
    send(32'h8765_4321, 4'd7, 4'b0000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_status", {28'd0, status}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("mrst_status_hold", {28'd0, status}, 32'd0);

    // Overflow counter saturation
    in_valid = 1'b1; in_flag_we = 1'b1; {in_s, in_o, in_z, in_c} = 4'b0100;
    for (int i = 0; i < 300; i++) begin
      in_result = 32'(i); in_dest = 4'(i);
      tick();
    end
    in_valid = 1'b0;
    drain();
    tick();
`ifdef ALU_WB_OVF_CNT_EN
    chk("ovf_sat", {24'd0, ovf_cnt}, 32'hFF);
`else
    chk("ovf_off", {24'd0, ovf_cnt}, 32'h0);
`endif
    chk("status_ovf", {28'd0, status}, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
